// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift-unit issue scheduler.
// Entry fields are sized to the largest supported configuration; users slice down.
package shift_sched_pkg;
  localparam int SHIFT_LAT  = 2;
  localparam int CNTRL_MAX  = 16;
  localparam int COMMIT_MAX = 8;
  localparam int HART_MAX   = 4;
  localparam int KILL_MAX   = 1 << HART_MAX;

  typedef struct packed {
    logic [CNTRL_MAX-1:0]  control;
    logic [COMMIT_MAX-1:0] rd;
    logic                  makes_rd;
    logic                  needs_rs2;
    logic [5:0]            immed;
    logic [HART_MAX-1:0]   hart;
    logic                  rv32;
  } q_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [COMMIT_MAX-1:0] rd;
    logic [HART_MAX-1:0]   hart;
    logic                  makes_rd;
    logic                  killed;
  } trk_t;

  function automatic logic kill_hit(input logic [KILL_MAX-1:0] kv, input logic [HART_MAX-1:0] h);
    return kv[h];
  endfunction
endpackage

// File: rtl/shift_sched_q.sv
// Two-entry per-requester op queue with push, pop and per-hart flush.
module shift_sched_q
  import shift_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  q_entry_t            push_e,
  input  logic                pop,
  input  logic [KILL_MAX-1:0] kill,
  output q_entry_t            head,
  output logic                head_vld,
  output logic                ready,
  output logic                nonempty
);
  q_entry_t   mem_q [2];
  q_entry_t   mem_d [2];
  logic       hd_q, hd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       occ0, occ1, live0, live1, keep0, wslot;

  // Survivors are compacted toward the head so a killed head lets the tail advance.
  always_comb begin
    occ0     = (cnt_q != 2'd0);
    occ1     = (cnt_q == 2'd2);
    head     = mem_q[hd_q];
    live0    = occ0 & ~kill_hit(kill, mem_q[hd_q].hart);
    live1    = occ1 & ~kill_hit(kill, mem_q[~hd_q].hart);
    head_vld = live0;
    keep0    = live0 & ~pop;
    hd_d     = (~keep0 & live1) ? ~hd_q : hd_q;
    cnt_d    = {1'b0, keep0} + {1'b0, live1};
    wslot    = hd_d ^ (cnt_d == 2'd1);
    mem_d    = mem_q;
    if (push && !kill_hit(kill, push_e.hart)) begin
      mem_d[wslot] = push_e;
      cnt_d        = cnt_d + 2'd1;
    end
  end

  assign ready    = (cnt_q != 2'd2);
  assign nonempty = occ0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      hd_q     <= hd_d;
      cnt_q    <= cnt_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end
endmodule

// File: rtl/shift_sched.sv
// Round-robin issue scheduler for the shared shift unit, with a result-latency
// tracker that aligns writeback and carries per-hart kills.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CNTRL_SIZE = 7,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int LNCOMMIT   = 5,
  parameter int LAT        = SHIFT_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*CNTRL_SIZE-1:0]   req_control,
  input  logic [NREQ*LNCOMMIT-1:0]     req_rd,
  input  logic [NREQ-1:0]              req_makes_rd,
  input  logic [NREQ-1:0]              req_needs_rs2,
  input  logic [NREQ*6-1:0]            req_immed,
  input  logic [NREQ*(LNHART+1)-1:0]   req_hart,
  input  logic [NREQ-1:0]              req_rv32,
  input  logic                         wb_stall,
  input  logic [NHART-1:0]             kill,
  output logic                         sh_enable,
  output logic [CNTRL_SIZE-1:0]        sh_control,
  output logic [LNCOMMIT-1:0]          sh_rd,
  output logic                         sh_makes_rd,
  output logic                         sh_needs_rs2,
  output logic [5:0]                   sh_immed,
  output logic [LNHART:0]              sh_hart,
  output logic                         sh_rv32,
  output logic [$clog2(NREQ)-1:0]      sh_src,
  output logic                         wb_valid,
  output logic [LNCOMMIT-1:0]          wb_rd,
  output logic [LNHART:0]              wb_hart,
  output logic                         wb_killed,
  output logic                         busy
);
  localparam int HW = LNHART + 1;
  localparam int LW = $clog2(NREQ);

  q_entry_t            push_e [NREQ];
  q_entry_t            head_e [NREQ];
  logic [NREQ-1:0]     push, pop, elig, nonempty;
  logic [KILL_MAX-1:0] kill_x;

  assign kill_x = KILL_MAX'(kill);
  assign push   = req_valid & req_ready;

  for (genvar i = 0; i < NREQ; i++) begin : g_q
    assign push_e[i] = '{
      control:   CNTRL_MAX'(req_control[i*CNTRL_SIZE +: CNTRL_SIZE]),
      rd:        COMMIT_MAX'(req_rd[i*LNCOMMIT +: LNCOMMIT]),
      makes_rd:  req_makes_rd[i],
      needs_rs2: req_needs_rs2[i],
      immed:     req_immed[i*6 +: 6],
      hart:      HART_MAX'(req_hart[i*HW +: HW]),
      rv32:      req_rv32[i]
    };
    shift_sched_q u_q (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .push_e   (push_e[i]),
      .pop      (pop[i]),
      .kill     (kill_x),
      .head     (head_e[i]),
      .head_vld (elig[i]),
      .ready    (req_ready[i]),
      .nonempty (nonempty[i])
    );
  end

  logic [LW-1:0] rr_q, rr_d, win, idx;
  logic          found, issue;
  q_entry_t      win_e;

  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = rr_q + LW'(o);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    issue = found & ~wb_stall;
    win_e = head_e[win];
    pop   = '0;
    if (issue) pop[win] = 1'b1;
    rr_d  = issue ? win + LW'(1) : rr_q;
  end

  always_comb begin
    sh_enable    = issue;
    sh_control   = '0;
    sh_rd        = '0;
    sh_makes_rd  = 1'b0;
    sh_needs_rs2 = 1'b0;
    sh_immed     = '0;
    sh_hart      = '0;
    sh_rv32      = 1'b0;
    sh_src       = '0;
    if (issue) begin
      sh_control   = win_e.control[CNTRL_SIZE-1:0];
      sh_rd        = win_e.rd[LNCOMMIT-1:0];
      sh_makes_rd  = win_e.makes_rd;
      sh_needs_rs2 = win_e.needs_rs2;
      sh_immed     = win_e.immed;
      sh_hart      = win_e.hart[HW-1:0];
      sh_rv32      = win_e.rv32;
      sh_src       = win;
    end
  end

  // Tracker mirrors the unit's pipeline; kills are folded in as ops advance.
  trk_t trk_q [LAT];
  trk_t trk_d [LAT];
  trk_t last;

  always_comb begin
    trk_d[0] = '0;
    if (issue) begin
      trk_d[0].valid    = 1'b1;
      trk_d[0].rd       = win_e.rd;
      trk_d[0].hart     = win_e.hart;
      trk_d[0].makes_rd = win_e.makes_rd;
      trk_d[0].killed   = kill_hit(kill_x, win_e.hart);
    end
    for (int s = 1; s < LAT; s++) begin
      trk_d[s]        = trk_q[s-1];
      trk_d[s].killed = trk_q[s-1].killed | (trk_q[s-1].valid & kill_hit(kill_x, trk_q[s-1].hart));
    end
  end

  assign last      = trk_q[LAT-1];
  assign wb_valid  = last.valid & last.makes_rd;
  assign wb_rd     = wb_valid ? last.rd[LNCOMMIT-1:0] : '0;
  assign wb_hart   = wb_valid ? last.hart[HW-1:0] : '0;
  assign wb_killed = wb_valid & (last.killed | kill_hit(kill_x, last.hart));

  always_comb begin
    busy = |nonempty;
    for (int s = 0; s < LAT; s++) busy = busy | trk_q[s].valid;
  end

  logic unused_hi;
  assign unused_hi = ^{win_e, last};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      for (int s = 0; s < LAT; s++) trk_q[s] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int s = 0; s < LAT; s++) trk_q[s] <= trk_d[s];
    end
  end
endmodule

// File: tb/tb_shift_sched.sv
// Scenario bench for shift_sched: issue timing, fairness, backpressure, kill,
// streaming and mid-flight reset, with a writeback scoreboard.
module tb_shift_sched;
  localparam int NREQ = 4, CS = 7, NHART = 2, LNHART = 1, LNC = 5, HW = LNHART + 1;

  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0, req_ready, req_makes_rd = '0, req_needs_rs2 = '0, req_rv32 = '0;
  logic [NREQ*CS-1:0]  req_control = '0;
  logic [NREQ*LNC-1:0] req_rd = '0;
  logic [NREQ*6-1:0]   req_immed = '0;
  logic [NREQ*HW-1:0]  req_hart = '0;
  logic                wb_stall = 1'b0;
  logic [NHART-1:0]    kill = '0;
  logic                sh_enable, sh_makes_rd, sh_needs_rs2, sh_rv32, wb_valid, wb_killed, busy;
  logic [CS-1:0]       sh_control;
  logic [LNC-1:0]      sh_rd, wb_rd;
  logic [5:0]          sh_immed;
  logic [HW-1:0]       sh_hart, wb_hart;
  logic [1:0]          sh_src;

  int total = 0, bad = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;

  always #5 clk = ~clk;

  shift_sched #(.NREQ(NREQ), .CNTRL_SIZE(CS), .NHART(NHART), .LNHART(LNHART), .LNCOMMIT(LNC), .LAT(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_control(req_control),
    .req_rd(req_rd), .req_makes_rd(req_makes_rd), .req_needs_rs2(req_needs_rs2), .req_immed(req_immed),
    .req_hart(req_hart), .req_rv32(req_rv32), .wb_stall(wb_stall), .kill(kill), .sh_enable(sh_enable),
    .sh_control(sh_control), .sh_rd(sh_rd), .sh_makes_rd(sh_makes_rd), .sh_needs_rs2(sh_needs_rs2),
    .sh_immed(sh_immed), .sh_hart(sh_hart), .sh_rv32(sh_rv32), .sh_src(sh_src), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_hart(wb_hart), .wb_killed(wb_killed), .busy(busy));

  // Writeback scoreboard: {killed, rd} in issue order.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL wb_unexpected: got rd=%0d killed=%b, nothing outstanding", wb_rd, wb_killed);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_killed, wb_rd} !== mon_e) begin
          bad++; $display("FAIL wb_order: got killed=%b rd=%0d want killed=%b rd=%0d", wb_killed, wb_rd, mon_e[5], mon_e[4:0]);
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_req(input int i, input int rd, input int hart, input int ctl, input int imm);
    req_rd[i*LNC +: LNC] = LNC'(rd);
    req_hart[i*HW +: HW] = HW'(hart);
    req_control[i*CS +: CS] = CS'(ctl);
    req_immed[i*6 +: 6] = 6'(imm);
    req_makes_rd[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; wb_stall = 1'b0; kill = '0; req_rv32 = '0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0;
    @(negedge clk);
    total++; if (req_ready !== 4'hf) begin bad++; $display("FAIL rst_ready: got %b want 1111", req_ready); end
    total++; if ({sh_enable, wb_valid, wb_killed, busy} !== 4'b0) begin bad++; $display("FAIL rst_outs: got %b want 0000", {sh_enable, wb_valid, wb_killed, busy}); end
    tick(); reset = 1'b0;
    @(negedge clk);
    total++; if ({req_ready, sh_enable, wb_valid, busy} !== 7'b1111_000) begin bad++; $display("FAIL rst_after: got %b want 1111000", {req_ready, sh_enable, wb_valid, busy}); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 5, 0, 7'h2a, 13); req_rv32[1] = 1'b1; req_valid = 4'b0010;
    @(negedge clk);
    total++; if (sh_enable !== 1'b0) begin bad++; $display("FAIL single_nobypass: got %b want 0", sh_enable); end
    tick(); req_valid = '0;
    @(negedge clk);
    total++; if ({sh_enable, sh_src, sh_rd} !== {1'b1, 2'd1, 5'd5}) begin bad++; $display("FAIL single_issue: got en=%b src=%0d rd=%0d want 1/1/5", sh_enable, sh_src, sh_rd); end
    total++; if ({sh_control, sh_immed, sh_rv32, sh_makes_rd} !== {7'h2a, 6'd13, 1'b1, 1'b1}) begin bad++; $display("FAIL single_fields: got ctl=%h imm=%0d rv32=%b mk=%b", sh_control, sh_immed, sh_rv32, sh_makes_rd); end
    exp_q.push_back({1'b0, 5'd5});
    tick(); @(negedge clk);
    total++; if ({wb_valid, busy} !== 2'b01) begin bad++; $display("FAIL single_c2: got wb=%b busy=%b want 0/1", wb_valid, busy); end
    tick(); @(negedge clk);
    total++; if ({wb_valid, wb_rd} !== {1'b1, 5'd5}) begin bad++; $display("FAIL single_wb: got wb=%b rd=%0d want 1/5", wb_valid, wb_rd); end
    tick(); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8 + i, 0, i, i);
    req_valid = 4'hf;
    for (int k = 1; k <= 12; k++) begin
      tick(); @(negedge clk);
      total++; if ({sh_enable, sh_src} !== {1'b1, 2'((k - 1) % NREQ)}) begin bad++; $display("FAIL fair_grant%0d: got en=%b src=%0d want 1/%0d", k, sh_enable, sh_src, (k - 1) % NREQ); end
      total++; if ($countones(req_ready) < 1) begin bad++; $display("FAIL fair_ready%0d: got %b want at least one set", k, req_ready); end
      exp_q.push_back({1'b0, 5'(8 + (k - 1) % NREQ)});
    end
    tick(); req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    wb_stall = 1'b1; set_req(0, 1, 0, 1, 1); req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_ready0: got %b want 1", req_ready[0]); end
    tick(); set_req(0, 2, 0, 2, 2);
    @(negedge clk);
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %b want 1", req_ready[0]); end
    tick(); set_req(0, 3, 0, 3, 3);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      total++; if ({req_ready[0], sh_enable} !== 2'b00) begin bad++; $display("FAIL bp_full%0d: got rdy=%b en=%b want 0/0", c, req_ready[0], sh_enable); end
      tick();
    end
    wb_stall = 1'b0;
    @(negedge clk);
    total++; if ({req_ready[0], sh_enable, sh_rd} !== {2'b01, 5'd1}) begin bad++; $display("FAIL bp_release: got rdy=%b en=%b rd=%0d want 0/1/1", req_ready[0], sh_enable, sh_rd); end
    exp_q.push_back({1'b0, 5'd1});
    tick(); @(negedge clk);
    total++; if ({req_ready[0], sh_enable, sh_rd} !== {2'b11, 5'd2}) begin bad++; $display("FAIL bp_third_push: got rdy=%b en=%b rd=%0d want 1/1/2", req_ready[0], sh_enable, sh_rd); end
    exp_q.push_back({1'b0, 5'd2});
    tick(); req_valid = '0; @(negedge clk);
    total++; if ({sh_enable, sh_rd} !== {1'b1, 5'd3}) begin bad++; $display("FAIL bp_third_issue: got en=%b rd=%0d want 1/3", sh_enable, sh_rd); end
    exp_q.push_back({1'b0, 5'd3});
    tick(); @(negedge clk);
    total++; if (sh_enable !== 1'b0) begin bad++; $display("FAIL bp_empty: got en=%b want 0", sh_enable); end
    repeat (2) tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_kill();
    do_reset();
    set_req(2, 20, 1, 0, 0); set_req(3, 21, 1, 0, 0); req_valid = 4'b1100;
    tick(); // cycle 1: A issues from requester 2
    set_req(3, 22, 1, 0, 0); set_req(0, 9, 0, 0, 0); req_valid = 4'b1001;
    @(negedge clk);
    total++; if ({sh_enable, sh_src, sh_rd} !== {1'b1, 2'd2, 5'd20}) begin bad++; $display("FAIL kill_first: got en=%b src=%0d rd=%0d want 1/2/20", sh_enable, sh_src, sh_rd); end
    exp_q.push_back({1'b1, 5'd20});
    tick(); // cycle 2: A in stage 1, B and C queued, D queued for hart 0
    req_valid = '0; wb_stall = 1'b1; kill = 2'b10;
    @(negedge clk);
    total++; if (sh_enable !== 1'b0) begin bad++; $display("FAIL kill_stall: got en=%b want 0", sh_enable); end
    tick(); wb_stall = 1'b0; kill = '0;
    @(negedge clk);
    total++; if ({wb_valid, wb_killed, wb_rd} !== {2'b11, 5'd20}) begin bad++; $display("FAIL kill_inflight: got wb=%b k=%b rd=%0d want 1/1/20", wb_valid, wb_killed, wb_rd); end
    total++; if ({sh_enable, sh_src, sh_rd} !== {1'b1, 2'd0, 5'd9}) begin bad++; $display("FAIL kill_hart0: got en=%b src=%0d rd=%0d want 1/0/9", sh_enable, sh_src, sh_rd); end
    exp_q.push_back({1'b0, 5'd9});
    for (int c = 4; c <= 5; c++) begin
      tick(); @(negedge clk);
      total++; if (sh_enable !== 1'b0) begin bad++; $display("FAIL kill_dropped%0d: got en=%b rd=%0d want 0", c, sh_enable, sh_rd); end
    end
    total++; if ({wb_valid, wb_killed, wb_rd} !== {2'b10, 5'd9}) begin bad++; $display("FAIL kill_hart0_wb: got wb=%b k=%b rd=%0d want 1/0/9", wb_valid, wb_killed, wb_rd); end
    tick(); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b0010; set_req(1, 10, 0, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10) set_req(1, 10 + k, 0, 0, 0); else req_valid = '0;
      @(negedge clk);
      if (k <= 10) begin
        total++; if ({sh_enable, sh_src, sh_rd} !== {1'b1, 2'd1, 5'(9 + k)}) begin bad++; $display("FAIL stream_issue%0d: got en=%b src=%0d rd=%0d want 1/1/%0d", k, sh_enable, sh_src, sh_rd, 9 + k); end
        total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b want 1", k, req_ready[1]); end
        exp_q.push_back({1'b0, 5'(9 + k)});
      end else begin
        total++; if (sh_enable !== 1'b0) begin bad++; $display("FAIL stream_end: got en=%b want 0", sh_enable); end
      end
    end
    repeat (2) tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_idle: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 1, 0, 0, 0); set_req(1, 2, 0, 0, 0); set_req(2, 3, 0, 0, 0); req_valid = 4'b0111;
    tick(); req_valid = 4'b0011; set_req(0, 4, 0, 0, 0); set_req(1, 6, 0, 0, 0);
    @(negedge clk);
    total++; if ({sh_enable, sh_src} !== 3'b100) begin bad++; $display("FAIL rmid_issue0: got en=%b src=%0d want 1/0", sh_enable, sh_src); end
    exp_q.push_back({1'b0, 5'd1});
    tick(); req_valid = '0;
    @(negedge clk);
    total++; if ({sh_enable, sh_src} !== 3'b101) begin bad++; $display("FAIL rmid_issue1: got en=%b src=%0d want 1/1", sh_enable, sh_src); end
    exp_q.push_back({1'b0, 5'd2});
    tick(); reset = 1'b1; exp_q.delete();
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      total++; if ({wb_valid, busy, sh_enable} !== 3'b000) begin bad++; $display("FAIL rmid_quiet%0d: got wb=%b busy=%b en=%b want 000", c, wb_valid, busy, sh_enable); end
      tick(); reset = 1'b0;
    end
    @(negedge clk);
    total++; if (req_ready !== 4'hf) begin bad++; $display("FAIL rmid_ready: got %b want 1111", req_ready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_kill();
    test_back_to_back();
    test_reset_midflight();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wb_missing: got %0d outstanding want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
